reg_file: RTL and testbench
===========================

# reg_file

Architectural register file and issue scoreboard for the CPU pipeline. It holds 16 × 16-bit registers and accepts the registered write-back port (`we`/`dst`/`out`) from the write stage. It also snoops the write stage's combinational result bus (`exe_en`/`exe_dst`/`exe_out`) for same-cycle forwarding. Two read ports serve the decode/issue stage, and each read port has an `ok` flag driven by a per-register pending-write scoreboard.

## Interface
Parameters:
- `REG_N`, 16: number of registers; the index is `$clog2(REG_N)` = 4 bits.
- `REG_W`, 16: register data width.
- `CNT_W`, 2: scoreboard pending-counter width per register. Maximum count is `2**CNT_W-1` = 3.

Ports:
- `cpu_clk`  in  1  clock; all state updates on the rising edge.
- `cpu_rst`  in  1  asynchronous, active-low reset.
- `we`  in  1  write-back enable from the write stage.
- `dst`  in  4  write-back register index.
- `out`  in  16  write-back data.
- `exe_en`  in  1  result-bus valid. Marks a result completing this cycle; `exe_dst`/`exe_out` are undefined (may be Z) when low.
- `exe_dst`  in  4  result-bus destination index.
- `exe_out`  in  16  result-bus data.
- `issue_en`  in  1  an instruction writing `issue_dst` is issued this cycle.
- `issue_dst`  in  4  destination index of the issuing instruction.
- `issue_rdy`  out  1  the pending counter of `issue_dst` is below its maximum.
- `rd_a_sel`, `rd_b_sel`  in  4  read indices.
- `rd_a_data`, `rd_b_data`  out  16  read data, combinational.
- `rd_a_ok`, `rd_b_ok`  out  1  read data is architecturally current.
- `sb_err`  out  1  sticky protocol-error flag.

## Operation
Register array:
- On each edge with `we`=1, `regs[dst] <= out`.
- Every register, including r0, is writable.

Read path, evaluated independently per port with source priority highest first:
1. `exe_en && exe_dst==sel` → `exe_out`.
2. `we && dst==sel` → `out`.
3. `regs[sel]`.

Scoreboard, one `cnt[i]` per register:
- **Increment:** `issue_en` increments `cnt[issue_dst]`.
- **Decrement:** `exe_en` decrements `cnt[exe_dst]`.
- **Same index both events:** the count is unchanged.
- **Issue while full:** `issue_en` with `cnt==3` is ignored. The count is not changed and `sb_err` is set.
- **Complete while empty:** `exe_en` with `cnt==0` leaves the count at 0 and sets `sb_err`.
- `sb_err` clears only on reset.

Port `ok` rule:
- `ok = (cnt[sel]==0) || (cnt[sel]==1 && exe_en && exe_dst==sel)`.
- When `cnt>=2`, `ok`=0 even if the result bus matches `sel`, because an older result is still in flight.
- `issue_rdy = cnt[issue_dst] != 3`. It does not depend on `issue_en`.

## Timing
- **Reset:** asynchronous on `cpu_rst`=0. All `regs`=0, all `cnt`=0, `sb_err`=0.
- **Outputs during reset:** `rd_*_data` = 0 or forwarded input per the priority rules; `rd_*_ok`=1 unless forwarding logic applies; `issue_rdy`=1.
- **Reset release mid-operation:** in-flight counts are lost. The bench must not drive `exe_en` for pre-reset issues.
- **Read latency:** 0 cycles. Purely combinational from `sel`, the array, and the two forwarding sources.
- **Write latency:** a result on the exe bus in cycle N is forwarded in N. It appears on `we`/`dst`/`out` in N+1, is in the array from N+2, and `cnt` has decremented from N+1.
- **Same-edge read of a written register:** forwarding from `we` covers the one-cycle gap.
- **Issue visibility:** issue in cycle N makes `ok`=0 for that index from N+1.
- **Simultaneous `rd_a_sel==rd_b_sel`:** both ports return identical data and `ok`.
- **Both forwarding sources match:** the exe bus wins, being the younger value.

## Structure
- `cpu_pkg` holds `REG_N`, `REG_W`, `reg_idx_t` (logic [3:0]), and `reg_data_t` (logic [15:0]), shared with the write and decode stages.
- Sub-module `reg_scoreboard` holds the counter array, the `ok`/`issue_rdy`/`sb_err` logic, and the increment/decrement arbitration.
- `reg_file` holds the data array, the read muxes, and an instance of `reg_scoreboard`.

## Test plan
- **Reset:** reset, then read r0..r15 → data 0x0000, `ok`=1, `issue_rdy`=1, `sb_err`=0.
- **Write and forward:** `we`=1, `dst`=5, `out`=0xBEEF for one cycle. `rd_a_sel`=5 shows 0xBEEF that cycle (forwarded) and the next (array).
- **Issue and complete:** issue r3 → `rd_a_ok`=0 next cycle. `exe_en`, `exe_dst`=3, `exe_out`=0x1234 → `rd_a_data`=0x1234 and `ok`=1 the same cycle. Then `cnt`=0 and the array holds 0x1234 two cycles later.
- **Double issue:** issue r7 twice. One `exe_en` for r7 → `ok`=0 that cycle. The second `exe_en` → `ok`=1.
- **Priority:** same cycle, `we` with `dst`=2/`out`=0xAAAA and `exe_en` with `exe_dst`=2/`exe_out`=0x5555 → both ports reading r2 return 0x5555.
- **Saturation and error:** issue r9 four times → `issue_rdy`=0 after the third, the fourth is ignored, and `sb_err`=1. `exe_en` on r4 with `cnt`=0 also sets `sb_err`. Assert reset mid-burst → all counts cleared and `sb_err`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared register-file types for the write, decode and register-file stages.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_N = 16;
  localparam int REG_W = 16;
  localparam int IDX_W = $clog2(REG_N);

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [REG_W-1:0] reg_data_t;

  // Read-port source select. The result bus is the youngest value, then the
  // registered write-back, then the architectural array.
  function automatic reg_data_t read_sel(
    input reg_idx_t  sel,
    input logic      exe_en,
    input reg_idx_t  exe_dst,
    input reg_data_t exe_out,
    input logic      we,
    input reg_idx_t  dst,
    input reg_data_t out,
    input reg_data_t arr_val
  );
    if (exe_en && exe_dst == sel) return exe_out;
    if (we && dst == sel)         return out;
    return arr_val;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Pipeline-facing bundle of the register file: write-back, result bus, issue, read ports.
// Latency: n/a (wires only).
// Backpressure: issue_rdy tells the issuer whether issue_dst can take another pending write.
// master = pipeline side (drives write-back/result/issue/selects), slave = reg_file.
interface reg_file_if;
  import cpu_pkg::*;

  logic      we;
  reg_idx_t  dst;
  reg_data_t out;
  logic      exe_en;
  reg_idx_t  exe_dst;
  reg_data_t exe_out;
  logic      issue_en;
  reg_idx_t  issue_dst;
  logic      issue_rdy;
  reg_idx_t  rd_a_sel;
  reg_idx_t  rd_b_sel;
  reg_data_t rd_a_data;
  reg_data_t rd_b_data;
  logic      rd_a_ok;
  logic      rd_b_ok;
  logic      sb_err;

  modport master (
    output we, dst, out, exe_en, exe_dst, exe_out, issue_en, issue_dst,
           rd_a_sel, rd_b_sel,
    input  issue_rdy, rd_a_data, rd_b_data, rd_a_ok, rd_b_ok, sb_err
  );

  modport slave (
    input  we, dst, out, exe_en, exe_dst, exe_out, issue_en, issue_dst,
           rd_a_sel, rd_b_sel,
    output issue_rdy, rd_a_data, rd_b_data, rd_a_ok, rd_b_ok, sb_err
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters driving the read-port ok flags and issue_rdy.
// Latency: counters update on the next edge; ok/issue_rdy are combinational from them.
// Backpressure: issue_rdy low when issue_dst is saturated; an issue then is dropped and flags sb_err.
// Ports: cpu_clk/cpu_rst, issue_en/issue_dst, exe_en/exe_dst, rd_a_sel/rd_b_sel in;
//        ok_a/ok_b, issue_rdy, sb_err (sticky) out.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic     cpu_clk,
  input  logic     cpu_rst,
  input  logic     issue_en,
  input  reg_idx_t issue_dst,
  input  logic     exe_en,
  input  reg_idx_t exe_dst,
  input  reg_idx_t rd_a_sel,
  input  reg_idx_t rd_b_sel,
  output logic     ok_a,
  output logic     ok_b,
  output logic     issue_rdy,
  output logic     sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt     [REG_N];
  logic [CNT_W-1:0] cnt_nxt [REG_N];
  logic             err_set;

  // An issue and a completion on the same register cancel out; otherwise
  // the two events touch different counters and are applied independently.
  always_comb begin
    cnt_nxt = cnt;
    err_set = 1'b0;
    if (!(issue_en && exe_en && issue_dst == exe_dst)) begin
      if (issue_en) begin
        if (cnt[issue_dst] == CNT_MAX) err_set = 1'b1;
        else                           cnt_nxt[issue_dst] = cnt[issue_dst] + 1'b1;
      end
      if (exe_en) begin
        if (cnt[exe_dst] == '0) err_set = 1'b1;
        else                    cnt_nxt[exe_dst] = cnt[exe_dst] - 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      for (int i = 0; i < REG_N; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sb_err <= sb_err | err_set;
    end
  end

  // A single outstanding write completing right now is forwarded, so the
  // read is current; with two or more in flight an older result still lands later.
  assign ok_a = (cnt[rd_a_sel] == '0) ||
                (cnt[rd_a_sel] == CNT_ONE && exe_en && exe_dst == rd_a_sel);
  assign ok_b = (cnt[rd_b_sel] == '0) ||
                (cnt[rd_b_sel] == CNT_ONE && exe_en && exe_dst == rd_b_sel);

  assign issue_rdy = (cnt[issue_dst] != CNT_MAX);

endmodule

// File: rtl/reg_file.sv
// Architectural register array with two forwarding read ports and an issue scoreboard.
// Latency: reads 0 cycles (combinational, forwarded); writes land in the array on the next edge.
// Backpressure: issue_rdy from the scoreboard; the write-back and result bus are never stalled.
// Ports: cpu_clk, cpu_rst (async active-low), bus (reg_file_if.slave).
module reg_file
  import cpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic       cpu_clk,
  input  logic       cpu_rst,
  reg_file_if.slave  bus
);

  reg_data_t regs [REG_N];

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (bus.we) begin
      regs[bus.dst] <= bus.out;
    end
  end

  assign bus.rd_a_data = read_sel(bus.rd_a_sel, bus.exe_en, bus.exe_dst, bus.exe_out,
                                  bus.we, bus.dst, bus.out, regs[bus.rd_a_sel]);
  assign bus.rd_b_data = read_sel(bus.rd_b_sel, bus.exe_en, bus.exe_dst, bus.exe_out,
                                  bus.we, bus.dst, bus.out, regs[bus.rd_b_sel]);

  reg_scoreboard #(
    .CNT_W (CNT_W)
  ) u_sb (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .issue_en  (bus.issue_en),
    .issue_dst (bus.issue_dst),
    .exe_en    (bus.exe_en),
    .exe_dst   (bus.exe_dst),
    .rd_a_sel  (bus.rd_a_sel),
    .rd_b_sel  (bus.rd_b_sel),
    .ok_a      (bus.rd_a_ok),
    .ok_b      (bus.rd_b_ok),
    .issue_rdy (bus.issue_rdy),
    .sb_err    (bus.sb_err)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a behavioural register/pending-count model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_reg_file;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  reg_file_if bus ();

  reg_file dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: architectural values, outstanding writes per register, error flag.
  logic [15:0] m_regs [16];
  int          m_cnt  [16];
  bit          m_err;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = 16'h0;
        m_cnt[i]  = 0;
      end
      m_err = 1'b0;
    end else begin
      if (bus.we) m_regs[bus.dst] = bus.out;
      if (!(bus.issue_en && bus.exe_en && bus.issue_dst == bus.exe_dst)) begin
        if (bus.issue_en) begin
          if (m_cnt[bus.issue_dst] >= 3) m_err = 1'b1;
          else m_cnt[bus.issue_dst] = m_cnt[bus.issue_dst] + 1;
        end
        if (bus.exe_en) begin
          if (m_cnt[bus.exe_dst] == 0) m_err = 1'b1;
          else m_cnt[bus.exe_dst] = m_cnt[bus.exe_dst] - 1;
        end
      end
    end
  end

  function automatic logic [15:0] exp_data(input logic [3:0] sel);
    if (bus.exe_en && bus.exe_dst == sel) return bus.exe_out;
    if (bus.we && bus.dst == sel)         return bus.out;
    return m_regs[sel];
  endfunction

  function automatic logic exp_ok(input logic [3:0] sel);
    return (m_cnt[sel] == 0) || (m_cnt[sel] == 1 && bus.exe_en && bus.exe_dst == sel);
  endfunction

  always @(negedge cpu_clk) begin
    if (chk_en) begin
      check("m_rd_a_data", bus.rd_a_data, exp_data(bus.rd_a_sel));
      check("m_rd_b_data", bus.rd_b_data, exp_data(bus.rd_b_sel));
      check("m_rd_a_ok",   16'(bus.rd_a_ok), 16'(exp_ok(bus.rd_a_sel)));
      check("m_rd_b_ok",   16'(bus.rd_b_ok), 16'(exp_ok(bus.rd_b_sel)));
      check("m_issue_rdy", 16'(bus.issue_rdy), 16'(m_cnt[bus.issue_dst] != 3));
      check("m_sb_err",    16'(bus.sb_err), 16'(m_err));
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0;       bus.dst = 4'd0;       bus.out = 16'h0;
    bus.exe_en = 1'b0;   bus.exe_dst = 4'd0;   bus.exe_out = 16'h0;
    bus.issue_en = 1'b0; bus.issue_dst = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    idle();
    bus.rd_a_sel = 4'd0;
    bus.rd_b_sel = 4'd0;
    cpu_rst = 1'b0;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk_en = 1'b1;

    // Reset readback of every register on both ports.
    for (int i = 0; i < 16; i++) begin
      bus.rd_a_sel  = 4'(i);
      bus.rd_b_sel  = 4'(15 - i);
      bus.issue_dst = 4'(i);
      @(negedge cpu_clk);
      check("rst_data_a", bus.rd_a_data, 16'h0000);
      check("rst_ok_a",   16'(bus.rd_a_ok), 16'h1);
      check("rst_rdy",    16'(bus.issue_rdy), 16'h1);
      check("rst_err",    16'(bus.sb_err), 16'h0);
      tick();
    end
    cpu_rst = 1'b1;
    tick();

    // Write-back r5 = BEEF: forwarded this cycle, from the array next cycle.
    bus.we = 1'b1; bus.dst = 4'd5; bus.out = 16'hBEEF; bus.rd_a_sel = 4'd5;
    @(negedge cpu_clk);
    check("wr_fwd", bus.rd_a_data, 16'hBEEF);
    tick();
    idle();
    @(negedge cpu_clk);
    check("wr_arr", bus.rd_a_data, 16'hBEEF);
    tick();

    // Issue r3, complete with 1234, then write it back.
    bus.issue_en = 1'b1; bus.issue_dst = 4'd3; bus.rd_a_sel = 4'd3;
    tick();
    idle();
    @(negedge cpu_clk);
    check("iss_ok0", 16'(bus.rd_a_ok), 16'h0);
    tick();
    bus.exe_en = 1'b1; bus.exe_dst = 4'd3; bus.exe_out = 16'h1234;
    @(negedge cpu_clk);
    check("exe_fwd", bus.rd_a_data, 16'h1234);
    check("exe_ok",  16'(bus.rd_a_ok), 16'h1);
    tick();
    idle();
    bus.we = 1'b1; bus.dst = 4'd3; bus.out = 16'h1234;
    @(negedge cpu_clk);
    check("wb_ok", 16'(bus.rd_a_ok), 16'h1);
    tick();
    idle();
    @(negedge cpu_clk);
    check("wb_arr", bus.rd_a_data, 16'h1234);
    tick();

    // Two outstanding writes to r7: the first completion is not enough.
    bus.issue_en = 1'b1; bus.issue_dst = 4'd7; bus.rd_a_sel = 4'd7;
    tick();
    tick();
    idle();
    bus.exe_en = 1'b1; bus.exe_dst = 4'd7; bus.exe_out = 16'h0707;
    @(negedge cpu_clk);
    check("dbl_ok0", 16'(bus.rd_a_ok), 16'h0);
    tick();
    bus.exe_out = 16'h7777;
    @(negedge cpu_clk);
    check("dbl_ok1", 16'(bus.rd_a_ok), 16'h1);
    check("dbl_dat", bus.rd_a_data, 16'h7777);
    tick();
    idle();

    // Priority: result bus beats write-back on both ports (r2 issued first).
    bus.issue_en = 1'b1; bus.issue_dst = 4'd2;
    tick();
    idle();
    bus.rd_a_sel = 4'd2; bus.rd_b_sel = 4'd2;
    bus.we = 1'b1;     bus.dst = 4'd2;     bus.out = 16'hAAAA;
    bus.exe_en = 1'b1; bus.exe_dst = 4'd2; bus.exe_out = 16'h5555;
    @(negedge cpu_clk);
    check("pri_a",  bus.rd_a_data, 16'h5555);
    check("pri_b",  bus.rd_b_data, 16'h5555);
    check("pri_ok", 16'(bus.rd_b_ok), 16'h1);
    tick();
    idle();
    @(negedge cpu_clk);
    check("pri_arr", bus.rd_a_data, 16'hAAAA);
    check("pri_err", 16'(bus.sb_err), 16'h0);
    tick();

    // Saturate r9: three issues accepted, the fourth dropped with an error.
    bus.rd_a_sel = 4'd9;
    bus.issue_en = 1'b1; bus.issue_dst = 4'd9;
    for (int k = 0; k < 4; k++) begin
      @(negedge cpu_clk);
      check("sat_rdy", 16'(bus.issue_rdy), (k < 3) ? 16'h1 : 16'h0);
      tick();
    end
    idle();
    bus.issue_dst = 4'd9;
    @(negedge cpu_clk);
    check("sat_err", 16'(bus.sb_err), 16'h1);
    check("sat_full", 16'(bus.issue_rdy), 16'h0);
    tick();
    bus.exe_en = 1'b1; bus.exe_dst = 4'd9; bus.exe_out = 16'h0909;
    tick();
    idle();
    bus.issue_dst = 4'd9;
    @(negedge cpu_clk);
    check("sat_dec_rdy", 16'(bus.issue_rdy), 16'h1);
    check("sat_dec_ok",  16'(bus.rd_a_ok), 16'h0);

    // Reset in the middle of an issue burst clears counts and the error.
    bus.issue_en = 1'b1;
    tick();
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    check("mid_rst_err", 16'(bus.sb_err), 16'h0);
    check("mid_rst_rdy", 16'(bus.issue_rdy), 16'h1);
    check("mid_rst_ok",  16'(bus.rd_a_ok), 16'h1);
    tick();
    idle();
    cpu_rst = 1'b1;
    tick();

    // Completion on an idle register flags the error.
    bus.exe_en = 1'b1; bus.exe_dst = 4'd4; bus.exe_out = 16'h4444;
    @(negedge cpu_clk);
    check("emp_err0", 16'(bus.sb_err), 16'h0);
    tick();
    idle();
    bus.rd_a_sel = 4'd4;
    @(negedge cpu_clk);
    check("emp_err1", 16'(bus.sb_err), 16'h1);
    check("emp_ok",   16'(bus.rd_a_ok), 16'h1);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
